jelly2_signal_packer: RTL and testbench



---
 rtl/jelly2_signal_packer.sv | 91 +++++++++
 tb/tb_jelly2_signal_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jelly2_signal_packer.sv
// Packs a stream of dataless signal tokens into counted batches on a registered valid/ready output.
// Optional JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN adds a 'flush' input that forces out a partial batch.
module jelly2_signal_packer #(
  parameter int unsigned COUNT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [COUNT_WIDTH-1:0]   threshold,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
`ifdef JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [COUNT_WIDTH-1:0]   m_count,
  output logic                     m_valid,
  input  logic                     m_ready
);

  logic [COUNT_WIDTH-1:0]   acc_q, acc_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic                     m_valid_q, m_valid_d;
  logic [COUNT_WIDTH-1:0]   m_count_q, m_count_d;

  logic                     accept;
  logic [COUNT_WIDTH-1:0]   acc_next;
  logic [COUNT_WIDTH-1:0]   thr_eff;
  logic [TIMEOUT_WIDTH-1:0] timeout_m1;
  logic                     has_tokens;
  logic                     thr_hit;
  logic                     timer_hit;
  logic                     force_hit;
  logic                     out_free;
  logic                     flush_req;
  logic                     fire;

  // Accumulator saturates by refusing tokens once full, so nothing is ever dropped.
  assign s_ready    = (acc_q != '1);
  assign accept     = s_valid & s_ready;
  assign acc_next   = acc_q + {{(COUNT_WIDTH-1){1'b0}}, accept};
  assign thr_eff    = (threshold == '0) ? COUNT_WIDTH'(1) : threshold;
  assign timeout_m1 = timeout - TIMEOUT_WIDTH'(1);
  assign has_tokens = (acc_next != '0);
  assign thr_hit    = (acc_next >= thr_eff);
  assign timer_hit  = (timeout != '0) && (timer_q == timeout_m1);
`ifdef JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN
  assign force_hit  = flush;
`else
  assign force_hit  = 1'b0;
`endif
  assign out_free   = ~m_valid_q | m_ready;
  assign flush_req  = has_tokens & (thr_hit | timer_hit | force_hit);
  assign fire       = flush_req & out_free;

  always_comb begin
    acc_d     = acc_next;
    timer_d   = timer_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_count_d = m_count_q;
    if (fire) begin
      acc_d     = '0;
      timer_d   = '0;
      m_valid_d = 1'b1;
      m_count_d = acc_next;
    end else if (!has_tokens) begin
      timer_d = '0;
    end else if (!timer_hit) begin
      // Holding at timeout-1 keeps a blocked timeout request alive until the output frees.
      timer_d = timer_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      timer_q   <= '0;
      m_valid_q <= 1'b0;
      m_count_q <= '0;
    end else begin
      acc_q     <= acc_d;
      timer_q   <= timer_d;
      m_valid_q <= m_valid_d;
      m_count_q <= m_count_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_count = m_count_q;

endmodule

// File: tb/tb_jelly2_signal_packer.sv
// Scoreboard bench for jelly2_signal_packer: stimulus queues expected batch counts, monitor checks.
module tb_jelly2_signal_packer;

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] threshold;
  logic [TW-1:0] timeout;
  logic [CW-1:0] m_count;
  logic          m_valid;
  logic          m_ready;
`ifdef JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int sum_pushed = 0;
  int sum_seen = 0;

  always #5 clk = ~clk;

  jelly2_signal_packer #(
    .COUNT_WIDTH  (CW),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .threshold(threshold),
    .timeout  (timeout),
`ifdef JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN
    .flush    (flush),
`endif
    .m_count  (m_count),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int cnt);
    exp_q.push_back(cnt);
    sum_pushed += cnt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every word handshaken on the next edge must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got m_count=%0d expected no word at %0t", m_count, $time);
      end else begin
        chk("batch_count", int'(m_count), exp_q.pop_front());
        sum_seen += int'(m_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    s_valid   = 1'b0;
    m_ready   = 1'b1;
    threshold = 4'd4;
    timeout   = '0;
`ifdef JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN
    flush     = 1'b0;
`endif
    #2;
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_m_count", int'(m_count), 0);
    chk("reset_s_ready", int'(s_ready), 1);
    #10 reset_n = 1'b1;
    step();

    // Threshold 4, eight back-to-back tokens: words after the 4th and 8th accept.
    push(4); push(4);
    s_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("thr4_s_ready", int'(s_ready), 1);
      step();
      chk("thr4_m_valid", int'(m_valid), (k % 4 == 0) ? 1 : 0);
    end
    s_valid = 1'b0;
    step();
    chk("thr4_drained", int'(m_valid), 0);

    // Timeout 5 with 3 tokens: partial word appears 5 cycles after the first accept.
    threshold = 4'd10;
    timeout   = 16'd5;
    push(3);
    s_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) s_valid = 1'b0;
      chk("tmo_m_valid", int'(m_valid), (k == 5) ? 1 : 0);
    end
    timeout = '0;

    // Blocked output: first word held, accumulator saturates at 15.
    threshold = 4'd2;
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    push(2);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 2) begin
        chk("hold_m_valid", int'(m_valid), 1);
        chk("hold_m_count", int'(m_count), 2);
      end
    end
    chk("sat_s_ready", int'(s_ready), 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    push(15);
    step();
    chk("sat_word_valid", int'(m_valid), 1);
    chk("sat_word_count", int'(m_count), 15);
    step();
    chk("sat_drained", int'(m_valid), 0);
    chk("sat_s_ready_back", int'(s_ready), 1);

    // Token on the flush cycle is part of the batch.
    threshold = 4'd3;
    push(3);
    s_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("flushcyc_m_valid", int'(m_valid), (k == 3) ? 1 : 0);
    end
    s_valid = 1'b0;
    step();
    chk("flushcyc_drained", int'(m_valid), 0);

    // Threshold 1: new flush coincides with consume, m_valid stays high.
    threshold = 4'd1;
    for (int k = 0; k < 4; k++) push(1);
    s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("b2b_m_valid", int'(m_valid), 1);
    end
    s_valid = 1'b0;
    step();
    chk("b2b_drained", int'(m_valid), 0);

    // Lowering threshold below the accumulated count flushes on the next edge.
    threshold = 4'd8;
    s_valid   = 1'b1;
    repeat (3) step();
    s_valid = 1'b0;
    chk("lower_pre", int'(m_valid), 0);
    threshold = 4'd2;
    push(3);
    step();
    chk("lower_m_valid", int'(m_valid), 1);
    step();
    chk("lower_drained", int'(m_valid), 0);

    // Asynchronous reset with acc=5 and a pending word discards both.
    threshold = 4'd2;
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    repeat (7) step();
    chk("prerst_m_valid", int'(m_valid), 1);
    s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_count", int'(m_count), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    #2 reset_n = 1'b1;
    m_ready = 1'b1;
    step();
    push(2);
    s_valid = 1'b1;
    step();
    chk("postrst_early", int'(m_valid), 0);
    step();
    chk("postrst_m_valid", int'(m_valid), 1);
    chk("postrst_m_count", int'(m_count), 2);
    s_valid = 1'b0;
    step();
    chk("postrst_drained", int'(m_valid), 0);

`ifdef JELLY2_SIGNAL_PACKER_FORCE_FLUSH_EN
    // Forced flush of a partial batch; flush with nothing accumulated is ignored.
    threshold = 4'd8;
    s_valid   = 1'b1;
    repeat (2) step();
    s_valid = 1'b0;
    flush   = 1'b1;
    push(2);
    step();
    chk("force_m_valid", int'(m_valid), 1);
    chk("force_m_count", int'(m_count), 2);
    flush = 1'b0;
    step();
    chk("force_drained", int'(m_valid), 0);
    flush = 1'b1;
    step();
    chk("force_empty", int'(m_valid), 0);
    flush = 1'b0;
    step();
    chk("force_empty_after", int'(m_valid), 0);
`endif

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    chk("token_sum", sum_seen, sum_pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
